fifo_ctrl: RTL

Pointer and status controller for the synchronous FIFO. It sits directly upstream of the FIFO storage RAM and drives that RAM's write-enable, write pointer and read pointer. It accepts raw write/read requests from the producer and consumer, qualifies them against the full/empty state, and reports occupancy and error status.
- Storage RAM: write is synchronous; read is asynchronous on the read pointer's low ADDR_WIDTH bits.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: address/data widths, depth and
// the wrap-bit pointer width used by the pointer and status logic.
package fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: advances by one on each enabled edge and wraps
// naturally modulo 2^WIDTH, so the MSB toggles once per lap of the RAM.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// Pointer and status controller for the synchronous FIFO: qualifies raw
// requests against full/empty, drives the RAM pointers and reports status.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int THRESHOLD  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  fifo_we,
  output logic                  fifo_rd,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_threshold,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] THRESH = PW'(THRESHOLD);

  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  fifo_ptr #(.WIDTH(PW)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fifo_we),
    .ptr_o (wptr)
  );

  fifo_ptr #(.WIDTH(PW)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fifo_rd),
    .ptr_o (rptr)
  );

  // Status depends only on the registered pointers, never on wr/rd.
  always_comb begin
    fifo_empty     = (wptr == rptr);
    fifo_full      = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    fifo_count     = wptr - rptr;
    fifo_threshold = (fifo_count >= THRESH);
  end

  always_comb begin
    fifo_we     = wr & ~fifo_full;
    fifo_rd     = rd & ~fifo_empty;
    overflow_d  = wr & fifo_full;
    underflow_d = rd & fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;

endmodule : fifo_ctrl
